// File: rtl/float_normalize_pkg.sv
// ============================================================================
// Module : float_normalize_pkg
// Brief  : Shared state encoding for the post-add normalizer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package float_normalize_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_SHIFT = 2'd1;
    localparam state_t c_ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/float_pack.sv
// ============================================================================
// Module : float_pack
// Brief  : Packs sign, exponent and fraction into an IEEE-style word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module float_pack #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic                           i_sign,
    input  logic [EXP_WIDTH-1:0]           i_exp,
    input  logic [MAN_WIDTH-1:0]           i_frac,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   o_word
);

    assign o_word = {i_sign, i_exp, i_frac};

endmodule

`default_nettype wire

// File: rtl/float_normalize.sv
// ============================================================================
// Module : float_normalize
// Brief  : Sequential post-add normalizer/packer, one left shift per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module float_normalize
    import float_normalize_pkg::*;
#(
    parameter  int EXP_WIDTH   = 8,
    parameter  int MAN_WIDTH   = 23,
    localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_WIDTH-1:0]   in_exp,
    input  logic [MAN_WIDTH+1:0]   in_man,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] out
);

    // One extra exponent bit so the carry increment cannot wrap.
    localparam logic [EXP_WIDTH:0] c_EXP_MAX = {1'b0, {EXP_WIDTH{1'b1}}};
    localparam logic [EXP_WIDTH:0] c_EXP_ONE = 1;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_in_ready;
    logic                   r_sign;
    logic [EXP_WIDTH:0]     r_exp;
    logic [MAN_WIDTH+1:0]   r_man;
    logic [FLOAT_WIDTH-1:0] r_out;

    logic                   w_accept;
    logic                   w_final;
    logic [EXP_WIDTH:0]     w_exp_inc;
    logic [EXP_WIDTH-1:0]   w_res_exp;
    logic [MAN_WIDTH-1:0]   w_res_frac;
    logic [FLOAT_WIDTH-1:0] w_packed;

    assign w_accept  = (r_state == c_ST_IDLE) && in_valid && r_in_ready;
    assign w_exp_inc = r_exp + c_EXP_ONE;

    // Priority-ordered finalize decision for the current SHIFT cycle.
    always_comb begin
        w_final    = 1'b1;
        w_res_exp  = '0;
        w_res_frac = '0;
        if (r_exp == c_EXP_MAX) begin
            w_res_exp  = r_exp[EXP_WIDTH-1:0];
            w_res_frac = r_man[MAN_WIDTH-1:0];
        end else if (r_man[MAN_WIDTH+1]) begin
            if (w_exp_inc >= c_EXP_MAX) begin
                w_res_exp = {EXP_WIDTH{1'b1}};
            end else begin
                w_res_exp  = w_exp_inc[EXP_WIDTH-1:0];
                w_res_frac = r_man[MAN_WIDTH:1];
            end
        end else if (r_man == '0) begin
            w_final = 1'b1;
        end else if (r_man[MAN_WIDTH]) begin
            w_res_exp  = r_exp[EXP_WIDTH-1:0];
            w_res_frac = r_man[MAN_WIDTH-1:0];
        end else if (r_exp <= c_EXP_ONE) begin
            w_final = 1'b1;
        end else begin
            w_final = 1'b0;
        end
    end

    float_pack #(
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH)
    ) u_pack (
        .i_sign (r_sign),
        .i_exp  (w_res_exp),
        .i_frac (w_res_frac),
        .o_word (w_packed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == c_ST_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept)  w_state_next = c_ST_SHIFT;
            c_ST_SHIFT: if (w_final)   w_state_next = c_ST_DONE;
            c_ST_DONE:  if (out_ready) w_state_next = c_ST_IDLE;
            default:                   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = r_in_ready;
        out_valid = (r_state == c_ST_DONE);
        out       = r_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_man  <= '0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_sign <= in_sign;
            r_exp  <= {1'b0, in_exp};
            r_man  <= in_man;
        end else if (r_state == c_ST_SHIFT) begin
            if (w_final) begin
                r_out <= w_packed;
            end else begin
                r_man <= {r_man[MAN_WIDTH:0], 1'b0};
                r_exp <= r_exp - c_EXP_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_float_normalize.sv
// ============================================================================
// Module : tb_float_normalize
// Brief  : Directed self-checking bench for float_normalize (8/23 format).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_float_normalize;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_man;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    float_normalize #(
        .EXP_WIDTH (8),
        .MAN_WIDTH (23)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic statement of the normalization rules: result word and shift count.
    function automatic void ref_model(input logic s, input int e, input int m,
                                      output logic [31:0] res, output int k);
        int p;
        int sh;
        int e2;
        k   = 0;
        res = {s, 31'b0};
        if (e == 255) begin
            res = {s, 31'b0} | 32'h7F800000 | (m & 32'h7FFFFF);
        end else if (m >= 32'h1000000) begin
            e2 = e + 1;
            if (e2 >= 255) res = {s, 31'b0} | 32'h7F800000;
            else           res = {s, 31'b0} | (e2 << 23) | ((m >> 1) & 32'h7FFFFF);
        end else if (m != 0) begin
            p = 0;
            for (int i = 0; i < 24; i++) if (((m >> i) & 1) == 1) p = i;
            sh = 23 - p;
            if (sh == 0 || e - sh >= 1) begin
                k   = sh;
                res = {s, 31'b0} | ((e - sh) << 23) | ((m << sh) & 32'h7FFFFF);
            end else begin
                k = (e <= 1) ? 0 : e - 1;
            end
        end
    endfunction

    // Cycle-level model of the handshake, driven by the same clock edges.
    logic        m_init = 1'b0;
    int          m_phase = 0;
    int          m_cnt = 0;
    logic        m_rdy = 1'b0;
    logic [31:0] m_out = '0;
    logic [31:0] m_pend = '0;
    logic        m_out_known = 1'b0;

    always @(posedge clk) begin
        int k;
        if (reset) begin
            m_init      = 1'b1;
            m_phase     = 0;
            m_rdy       = 1'b0;
            m_out       = '0;
            m_out_known = 1'b1;
        end else if (m_init) begin
            case (m_phase)
                0: begin
                    if (in_valid && m_rdy) begin
                        ref_model(in_sign, int'(in_exp), int'(in_man), m_pend, k);
                        m_cnt   = k + 1;
                        m_phase = 1;
                        m_rdy   = 1'b0;
                    end else begin
                        m_rdy = 1'b1;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase     = 2;
                        m_out       = m_pend;
                        m_out_known = 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        m_phase     = 0;
                        m_rdy       = 1'b1;
                        m_out_known = 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", 32'(in_ready), 32'(m_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            if (m_out_known) chk("out", out, m_out);
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string name, input logic [31:0] exp_out, input int exp_lat,
                           input int hold, input bit b2b);
        int c = 0;
        while (!out_valid && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_lat"}, 32'(c), 32'(exp_lat));
        chk({name, "_out"}, out, exp_out);
        for (int h = 0; h < hold; h++) begin
            if (b2b) begin
                in_valid = 1'b1;
                in_sign  = 1'b0;
                in_exp   = 8'h7F;
                in_man   = 25'h1800000;
            end
            @(negedge clk);
            chk({name, "_hold_out"}, out, exp_out);
            chk({name, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_post_rdy"}, 32'(in_ready), 32'd1);
        if (b2b) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] r;
        int          k;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_rdy", 32'(in_ready), 32'd1);

        ref_model(1'b0, 'h7F, 'h1800000, r, k);
        chk("model_carry", r, 32'h40400000);
        ref_model(1'b0, 'h82, 'h0100000, r, k);
        chk("model_lsh3", r, 32'h3F800000);
        chk("model_lsh3_k", 32'(k), 32'd3);
        ref_model(1'b0, 'h03, 'h0100000, r, k);
        chk("model_flush_k", 32'(k), 32'd2);

        send(1'b0, 8'h7F, 25'h1800000); collect("carry", 32'h40400000, 1, 0, 1'b0);
        send(1'b0, 8'h7F, 25'h0800000); collect("norm", 32'h3F800000, 1, 5, 1'b1);
        collect("b2b", 32'h40400000, 1, 0, 1'b0);
        send(1'b0, 8'h82, 25'h0100000); collect("lsh3", 32'h3F800000, 4, 0, 1'b0);
        send(1'b1, 8'h90, 25'h0000000); collect("zero", 32'h80000000, 1, 0, 1'b0);
        send(1'b0, 8'h01, 25'h0400000); collect("uflow", 32'h00000000, 1, 0, 1'b0);
        send(1'b0, 8'hFE, 25'h1000000); collect("oflow", 32'h7F800000, 1, 0, 1'b0);
        send(1'b0, 8'hFF, 25'h0400001); collect("nan", 32'h7FC00001, 1, 0, 1'b0);
        send(1'b0, 8'h03, 25'h0100000); collect("flush_sh", 32'h00000000, 3, 0, 1'b0);
        send(1'b0, 8'h03, 25'h0200000); collect("min_norm", 32'h00800000, 3, 0, 1'b0);

        send(1'b0, 8'h90, 25'h0000001);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", out, 32'h0);
        chk("midrst_rdy", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_release_rdy", 32'(in_ready), 32'd1);
        repeat (30) @(negedge clk);
        chk("midrst_no_valid", 32'(out_valid), 32'd0);

        send(1'b1, 8'h90, 25'h0000001); collect("worst", 32'hBC800000, 24, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
